// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue stage: op encodings, datapath
// width, and the request/result records carried by the pipeline slots.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    localparam logic [1:0] ALU_OP_ADD  = 2'b00;
    localparam logic [1:0] ALU_OP_SUB  = 2'b01;
    localparam logic [1:0] ALU_OP_XOR  = 2'b10;
    localparam logic [1:0] ALU_OP_ANDN = 2'b11;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] a;
        logic [ALU_WIDTH-1:0] b;
        logic [1:0]           op;
        logic                 sign;
        logic                 cin;
    } alu_req_t;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] data;
        logic                 ofl;
        logic                 zero;
        logic                 neg;
    } alu_res_t;

endpackage

// File: rtl/alu_pipe_reg.sv
// One pipeline slot: a valid bit plus a data record that loads on demand and
// otherwise holds, so idle slots keep presenting their last contents.
module alu_pipe_reg #(
    parameter type T = logic
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic valid_d,
    input  T     data_d,
    output logic valid_q,
    output T     data_q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            // NOTE: the data record is reset as well as the valid bit, so that
            // every visible output is a known 0 straight out of reset; a slot
            // whose data is never observed before being loaded could skip this.
            data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, regardless of statement or process order.
            valid_q <= valid_d;
            if (load) begin
                data_q <= data_d;
            end
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Two-stage valid/ready wrapper around an external arith unit, with a
// saturating overflow counter. Define ALU_OFL_TRAP_EN to add the trap/trap_clr stall.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH     = ALU_WIDTH,
    parameter int OFL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [1:0]           in_op,
    input  logic                 in_sign,
    input  logic                 in_cin,
    output logic [WIDTH-1:0]     arith_a,
    output logic [WIDTH-1:0]     arith_b,
    output logic [1:0]           arith_op,
    output logic                 arith_sign,
    output logic                 arith_cin,
    input  logic [WIDTH-1:0]     arith_out,
    input  logic                 arith_ofl,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [WIDTH-1:0]     res_data,
    output logic                 res_ofl,
    output logic                 res_zero,
    output logic                 res_neg,
`ifdef ALU_OFL_TRAP_EN
    output logic                 trap,
    input  logic                 trap_clr,
`endif
    output logic [OFL_CNT_W-1:0] ofl_cnt
);

    alu_req_t               s1_req_d, s1_req_q;
    alu_res_t               s2_res_d, s2_res_q;
    logic                   v1_d, v1_q, v2_d, v2_q;
    logic                   s1_load, s2_load, s2_adv;
    logic                   trap_hold;
    logic [OFL_CNT_W-1:0]   ofl_cnt_d, ofl_cnt_q;

    always_comb begin
        // NOTE: every signal driven here gets an unconditional assignment
        // before any branch, so no path can leave it unassigned (no latches).
        ofl_cnt_d = ofl_cnt_q;

        s2_adv   = (~v2_q | res_ready) & ~trap_hold;
        in_ready = ~v1_q | s2_adv;
        s1_load  = in_valid & in_ready;
        s2_load  = v1_q & s2_adv;
        v1_d     = s1_load | (v1_q & ~s2_adv);
        v2_d     = s2_load | (v2_q & ~res_ready);

        s1_req_d = '{a: in_a, b: in_b, op: in_op, sign: in_sign, cin: in_cin};
        // Flags are derived from the captured value so they travel with it.
        s2_res_d = '{data: arith_out,
                     ofl:  arith_ofl,
                     zero: (arith_out == '0),
                     neg:  arith_out[WIDTH-1]};

        if (s2_load && arith_ofl && (ofl_cnt_q != '1)) begin
            ofl_cnt_d = ofl_cnt_q + OFL_CNT_W'(1);
        end
    end

    alu_pipe_reg #(.T(alu_req_t)) u_s1 (
        .clk     (clk),
        .rst     (rst),
        .load    (s1_load),
        .valid_d (v1_d),
        .data_d  (s1_req_d),
        .valid_q (v1_q),
        .data_q  (s1_req_q)
    );

    alu_pipe_reg #(.T(alu_res_t)) u_s2 (
        .clk     (clk),
        .rst     (rst),
        .load    (s2_load),
        .valid_d (v2_d),
        .data_d  (s2_res_d),
        .valid_q (v2_q),
        .data_q  (s2_res_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ofl_cnt_q <= '0;
        end else begin
            ofl_cnt_q <= ofl_cnt_d;
        end
    end

`ifdef ALU_OFL_TRAP_EN
    logic trap_d, trap_q;

    // A fresh overflow capture wins over a simultaneous clear.
    always_comb begin
        trap_d = trap_q;
        if (s2_load && arith_ofl) begin
            trap_d = 1'b1;
        end else if (trap_clr) begin
            trap_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= trap_d;
        end
    end

    assign trap      = trap_q;
    assign trap_hold = trap_q;
`else
    assign trap_hold = 1'b0;
`endif

    assign arith_a    = s1_req_q.a;
    assign arith_b    = s1_req_q.b;
    assign arith_op   = s1_req_q.op;
    assign arith_sign = s1_req_q.sign;
    assign arith_cin  = s1_req_q.cin;

    assign res_valid  = v2_q;
    assign res_data   = s2_res_q.data;
    assign res_ofl    = s2_res_q.ofl;
    assign res_zero   = s2_res_q.zero;
    assign res_neg    = s2_res_q.neg;
    assign ofl_cnt    = ofl_cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage plus a behavioural arith unit; a transaction-level
// model is compared against the DUT on every falling edge.
module tb_alu_issue_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0, in_b = '0;
    logic [1:0]  in_op = '0;
    logic        in_sign = 1'b0, in_cin = 1'b0;
    logic [15:0] arith_a, arith_b, arith_out;
    logic [1:0]  arith_op;
    logic        arith_sign, arith_cin, arith_ofl;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic        res_ofl, res_zero, res_neg;
    logic [7:0]  ofl_cnt;
`ifdef ALU_OFL_TRAP_EN
    logic        trap;
    logic        trap_clr = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.WIDTH(16), .OFL_CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .in_sign    (in_sign),
        .in_cin     (in_cin),
        .arith_a    (arith_a),
        .arith_b    (arith_b),
        .arith_op   (arith_op),
        .arith_sign (arith_sign),
        .arith_cin  (arith_cin),
        .arith_out  (arith_out),
        .arith_ofl  (arith_ofl),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_ofl    (res_ofl),
        .res_zero   (res_zero),
        .res_neg    (res_neg),
`ifdef ALU_OFL_TRAP_EN
        .trap       (trap),
        .trap_clr   (trap_clr),
`endif
        .ofl_cnt    (ofl_cnt)
    );

    // Arithmetic rules of the arith unit, used both as the unit itself and by the model.
    function automatic alu_res_t ref_alu(input alu_req_t r);
        logic [16:0] w;
        alu_res_t    o;
        o = '0;
        case (r.op)
            ALU_OP_ADD: begin
                w = {1'b0, r.a} + {1'b0, r.b} + {16'd0, r.cin};
                o.data = w[15:0];
                o.ofl  = r.sign ? (r.a[15] == r.b[15] && o.data[15] != r.a[15]) : w[16];
            end
            ALU_OP_SUB: begin
                w = {1'b0, r.a} - {1'b0, r.b};
                o.data = w[15:0];
                o.ofl  = r.sign ? (r.a[15] != r.b[15] && o.data[15] != r.a[15]) : w[16];
            end
            ALU_OP_XOR:  o.data = r.a ^ r.b;
            default:     o.data = r.a & ~r.b;
        endcase
        o.zero = (o.data == 16'd0);
        o.neg  = o.data[15];
        return o;
    endfunction

    alu_res_t arith_res;
    always_comb begin
        arith_res = ref_alu('{a: arith_a, b: arith_b, op: arith_op, sign: arith_sign, cin: arith_cin});
        arith_out = arith_res.data;
        arith_ofl = arith_res.ofl;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: requests in flight, oldest first. An entry is
    // "done" once its result has been registered for the consumer.
    typedef struct {
        alu_req_t req;
        alu_res_t res;
        bit       done;
    } flight_t;

    flight_t  flight[$];
    alu_req_t m_last = '0;
    int       m_ofl_total = 0;
    bit       m_trap = 1'b0;
    bit       m_head_ready, m_pop, m_waiting, m_adv, m_exp_ready;
    int       m_done_after;
    flight_t  m_new;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_in_ready", in_ready, 1);
            check("rst_res_valid", res_valid, 0);
            check("rst_ofl_cnt", ofl_cnt, 0);
            check("rst_res_data", res_data, 0);
            check("rst_arith_a", arith_a, 0);
`ifdef ALU_OFL_TRAP_EN
            check("rst_trap", trap, 0);
`endif
            flight.delete();
            m_last = '0;
            m_ofl_total = 0;
            m_trap = 1'b0;
        end else begin
            m_head_ready = flight.size() > 0 && flight[0].done;
            m_pop        = m_head_ready && res_ready;
            m_waiting    = flight.size() > 0 && !flight[flight.size()-1].done;
            m_done_after = (m_head_ready ? 1 : 0) - (m_pop ? 1 : 0);
            m_adv        = m_waiting && m_done_after == 0 && !m_trap;
            m_exp_ready  = !m_waiting || ((m_done_after == 0) && !m_trap);

            check("in_ready", in_ready, m_exp_ready);
            check("res_valid", res_valid, m_head_ready);
            if (m_head_ready) begin
                check("res_data", res_data, flight[0].res.data);
                check("res_ofl", res_ofl, flight[0].res.ofl);
                check("res_zero", res_zero, flight[0].res.zero);
                check("res_neg", res_neg, flight[0].res.neg);
            end
            check("ofl_cnt", ofl_cnt, (m_ofl_total > 255) ? 255 : m_ofl_total);
            check("arith_req", {arith_a, arith_b, arith_op, arith_sign, arith_cin}, m_last);
`ifdef ALU_OFL_TRAP_EN
            check("trap", trap, m_trap);
`endif

            if (m_pop) void'(flight.pop_front());
            if (m_adv) begin
                flight[flight.size()-1].res  = ref_alu(flight[flight.size()-1].req);
                flight[flight.size()-1].done = 1'b1;
                if (flight[flight.size()-1].res.ofl) m_ofl_total++;
            end
`ifdef ALU_OFL_TRAP_EN
            if (m_adv && flight[flight.size()-1].res.ofl) m_trap = 1'b1;
            else if (trap_clr) m_trap = 1'b0;
`endif
            if (in_valid && m_exp_ready) begin
                m_new.req  = '{a: in_a, b: in_b, op: in_op, sign: in_sign, cin: in_cin};
                m_new.res  = '0;
                m_new.done = 1'b0;
                flight.push_back(m_new);
                m_last = m_new.req;
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                         input logic sign, input logic cin, output int cycles);
        bit ok;
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_sign = sign; in_cin = cin;
        cycles = 0;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            cycles++;
        end while (!ok && cycles < 200);
        if (!ok) check("issue_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'h7FFF;
            2:       return 16'h8000;
            3:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc, c1, c2, c3, k;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 1: add, two-edge latency
        res_ready = 1'b1;
        issue(16'h0003, 16'h0004, ALU_OP_ADD, 1'b0, 1'b0, cyc);
        check("t1_accept_first_try", cyc, 1);
        check("t1_not_yet_valid", res_valid, 0);
        idle(1);
        check("t1_valid", res_valid, 1);
        check("t1_data", res_data, 16'h0007);
        check("t1_flags", {res_zero, res_neg, res_ofl}, 3'b000);

        // 2: sub to zero
        issue(16'h0005, 16'h0005, ALU_OP_SUB, 1'b0, 1'b0, cyc);
        idle(1);
        check("t2_data", res_data, 16'h0000);
        check("t2_zero_ofl", {res_zero, res_ofl}, 2'b10);

        // 3: back-to-back xor, andn, add
        issue(16'h00FF, 16'h0F0F, ALU_OP_XOR, 1'b0, 1'b0, c1);
        issue(16'hF0F0, 16'h00FF, ALU_OP_ANDN, 1'b0, 1'b0, c2);
        issue(16'h1234, 16'h1111, ALU_OP_ADD, 1'b0, 1'b1, c3);
        check("t3_b2b_accepts", {c1[7:0], c2[7:0], c3[7:0]}, 24'h010101);
        idle(1);
        check("t3_last_data", res_data, 16'h2346);
        idle(3);

        // 4: stall with res_ready low
        res_ready = 1'b0;
        issue(16'h0010, 16'h0001, ALU_OP_ADD, 1'b0, 1'b0, c1);
        issue(16'h0020, 16'h0003, ALU_OP_XOR, 1'b0, 1'b0, c2);
        check("t4_two_accepts", {c1[7:0], c2[7:0]}, 16'h0101);
        in_valid = 1'b1; in_a = 16'h0030; in_b = 16'h0001; in_op = ALU_OP_SUB;
        repeat (3) @(posedge clk);
        #1;
        check("t4_in_ready_low", in_ready, 0);
        check("t4_head_held", res_data, 16'h0011);
        res_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("t4_second", res_data, 16'h0023);
        @(posedge clk);
        #1;
        check("t4_third", res_data, 16'h002F);
        check("t4_third_valid", res_valid, 1);
        idle(3);

        // 5: repeated signed overflow, counter saturates
        issue(16'h7FFF, 16'h0001, ALU_OP_ADD, 1'b1, 1'b0, cyc);
        idle(1);
        check("t5_first_data", res_data, 16'h8000);
        check("t5_first_ofl_neg", {res_ofl, res_neg}, 2'b11);
        check("t5_first_cnt", ofl_cnt, 1);
`ifdef ALU_OFL_TRAP_EN
        check("t5_trap_set", trap, 1);
        trap_clr = 1'b1;
        @(posedge clk);
        #1 trap_clr = 1'b0;
`endif
        for (int i = 1; i < 300; i++) begin
            issue(16'h7FFF, 16'h0001, ALU_OP_ADD, 1'b1, 1'b0, cyc);
`ifdef ALU_OFL_TRAP_EN
            in_valid = 1'b0;
            k = 0;
            while (!trap && k < 20) begin
                @(posedge clk);
                #1 k++;
            end
            check("t5_trap_wait", trap, 1);
            trap_clr = 1'b1;
            @(posedge clk);
            #1 trap_clr = 1'b0;
`endif
        end
        idle(3);
        check("t5_cnt_saturated", ofl_cnt, 8'hFF);

        // 6: asynchronous reset with both stages full
        res_ready = 1'b0;
        issue(16'h0001, 16'h0002, ALU_OP_ADD, 1'b0, 1'b0, cyc);
        issue(16'h0003, 16'h0004, ALU_OP_ADD, 1'b0, 1'b0, cyc);
        in_valid = 1'b0;
        check("t6_full_in_ready", in_ready, 0);
        #2 rst = 1'b1;
        #1;
        check("t6_async_res_valid", res_valid, 0);
        check("t6_async_ofl_cnt", ofl_cnt, 0);
        check("t6_async_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            res_ready = ($urandom_range(0, 9) < 7);
            in_a      = pick();
            in_b      = pick();
            in_op     = 2'($urandom_range(0, 3));
            in_sign   = 1'($urandom);
            in_cin    = 1'($urandom);
`ifdef ALU_OFL_TRAP_EN
            trap_clr  = ($urandom_range(0, 3) == 0);
`endif
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
`ifdef ALU_OFL_TRAP_EN
        trap_clr  = 1'b1;
`endif
        repeat (6) @(posedge clk);
        #1;
        check("final_drained", res_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
